// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read master port between instruction fetch (0) and data load (1).
// Optional macro RD_ARB_RR_EN selects round-robin tie-breaking; without it requester 1 wins ties.
`timescale 1ns/1ps

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module axi_rd_arbiter (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        req0,
  input  logic                        req1,
  input  logic [`AXI_ADDR_BITS-1:0]   addr0,
  input  logic [`AXI_ADDR_BITS-1:0]   addr1,
  input  logic [`AXI_LEN_BITS-1:0]    len0,
  input  logic [`AXI_LEN_BITS-1:0]    len1,
  output logic                        gnt0,
  output logic                        gnt1,
  output logic                        rvalid0,
  output logic                        rvalid1,
  output logic                        rlast_o,
  output logic [`AXI_DATA_BITS-1:0]   rdata_o,
  output logic [1:0]                  rresp_o,
  output logic                        stall0,
  output logic                        stall1,
  output logic                        len_err,
  output logic [`AXI_ID_BITS-1:0]     ARID_M,
  output logic [`AXI_ADDR_BITS-1:0]   ARADDR_M,
  output logic [`AXI_LEN_BITS-1:0]    ARLEN_M,
  output logic [`AXI_SIZE_BITS-1:0]   ARSIZE_M,
  output logic [1:0]                  ARBURST_M,
  output logic                        ARVALID_M,
  input  logic                        ARREADY_M,
  input  logic [`AXI_ID_BITS-1:0]     RID_M,
  input  logic [`AXI_DATA_BITS-1:0]   RDATA_M,
  input  logic [1:0]                  RRESP_M,
  input  logic                        RLAST_M,
  input  logic                        RVALID_M,
  output logic                        RREADY_M
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} arbState_t;

  localparam logic [`AXI_LEN_BITS-1:0] LEN_MAX = '1;

  arbState_t                  r_state;
  arbState_t                  w_nextState;
  logic [`AXI_ADDR_BITS-1:0]  r_addr;
  logic [`AXI_LEN_BITS-1:0]   r_len;
  logic [`AXI_LEN_BITS-1:0]   r_cnt;
  logic                       r_gntIdx;
  logic                       w_anyReq;
  logic                       w_winner;
  logic                       w_beat;
  logic                       w_unusedRid;

  assign w_anyReq = req0 | req1;

`ifdef RD_ARB_RR_EN
  logic r_lastGnt;

  // Pointer remembers the last winner so a tie goes to the other requester.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_lastGnt <= 1'b1;
    end else if (r_state == IDLE && w_anyReq) begin
      r_lastGnt <= w_winner;
    end
  end

  always_comb begin
    w_winner = 1'b0;
    if (req0 && req1) begin
      w_winner = ~r_lastGnt;
    end else if (req1) begin
      w_winner = 1'b1;
    end
  end
`else
  assign w_winner = req1;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    ARVALID_M   = 1'b0;
    RREADY_M    = 1'b0;
    w_beat      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_nextState = ADDR;
        end
      end
      ADDR: begin
        ARVALID_M = 1'b1;
        if (ARREADY_M) begin
          w_nextState = DATA;
        end
      end
      DATA: begin
        RREADY_M = 1'b1;
        w_beat   = RVALID_M;
        if (RVALID_M && RLAST_M) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Burst parameters are captured at grant so requesters may change their inputs afterwards.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_addr   <= '0;
      r_len    <= '0;
      r_gntIdx <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == IDLE && w_anyReq) begin
      r_gntIdx <= w_winner;
      r_addr   <= w_winner ? addr1 : addr0;
      r_len    <= w_winner ? len1 : len0;
      r_cnt    <= '0;
    end else if (w_beat) begin
      if (!RLAST_M && r_cnt == r_len) begin
        r_cnt <= LEN_MAX;
      end else if (r_cnt != LEN_MAX) begin
        r_cnt <= r_cnt + `AXI_LEN_BITS'(1);
      end
    end
  end

  assign gnt0 = (r_state != IDLE) && !r_gntIdx;
  assign gnt1 = (r_state != IDLE) &&  r_gntIdx;

  assign rvalid0 = w_beat && !r_gntIdx;
  assign rvalid1 = w_beat &&  r_gntIdx;
  assign rlast_o = w_beat && RLAST_M;
  assign rdata_o = w_beat ? RDATA_M : '0;
  assign rresp_o = w_beat ? RRESP_M : 2'b00;

  assign stall0 = req0 && !(rvalid0 && rlast_o);
  assign stall1 = req1 && !(rvalid1 && rlast_o);

  // Mismatch is either an early RLAST or a missing RLAST on the expected final beat.
  assign len_err = w_beat && (RLAST_M ? (r_cnt != r_len) : (r_cnt == r_len));

  assign ARID_M    = {{(`AXI_ID_BITS-1){1'b0}}, r_gntIdx};
  assign ARADDR_M  = r_addr;
  assign ARLEN_M   = r_len;
  assign ARSIZE_M  = `AXI_SIZE_BITS'(3'b010);
  assign ARBURST_M = 2'b01;

  assign w_unusedRid = ^RID_M;

endmodule
